// File: rtl/see_pkg.sv
// Shared types for the single-event fault campaign: fault modes, FSM states
// and the fault-site index width helper.
package see_pkg;

    typedef enum logic [1:0] {
        FM_SA0  = 2'b00,
        FM_SA1  = 2'b01,
        FM_FLIP = 2'b10,
        FM_NONE = 2'b11
    } fault_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_RUN,
        ST_FLUSH,
        ST_REPORT,
        ST_DONE
    } state_e;

    // Bits needed to index the N_IN-1 fault sites; never narrower than 1.
    function automatic int site_width(input int n_in);
        int w;
        w = $clog2(n_in - 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/see_cone.sv
// AND-pair / OR-reduce logic cone with an optional fault injected on one
// internal node n[k] = in[k] & in[k+1].
module see_cone
    import see_pkg::*;
#(
    parameter int N_IN   = 8,
    parameter int SITE_W = 3
) (
    input  logic [N_IN-1:0]   in,
    input  logic              fault_en,
    input  logic [SITE_W-1:0] fault_site,
    input  fault_mode_e       fault_mode,
    output logic              out
);

    logic [N_IN-2:0] n_mod;

    generate
        for (genvar gi = 0; gi < N_IN - 1; gi++) begin : g_site
            logic n_raw;
            logic n_bit;

            assign n_raw = in[gi] & in[gi+1];

            always_comb begin
                n_bit = n_raw;
                if (fault_en && (fault_site == SITE_W'(gi))) begin
                    case (fault_mode)
                        FM_SA0:  n_bit = 1'b0;
                        FM_SA1:  n_bit = 1'b1;
                        FM_FLIP: n_bit = ~n_raw;
                        default: n_bit = n_raw;
                    endcase
                end
            end

            assign n_mod[gi] = n_bit;
        end
    endgenerate

    assign out = |n_mod;

endmodule

// File: rtl/see_fault_campaign.sv
// Sweeps a fault across every site of the cone, counting golden/faulty
// output mismatches over an LFSR pattern sequence and reporting per site.
module see_fault_campaign
    import see_pkg::*;
#(
    parameter int              N_IN      = 8,
    parameter int              N_PAT     = 256,
    parameter int              CNT_W     = 16,
    parameter logic [N_IN-1:0] LFSR_TAPS = N_IN'(8'hB8),
    localparam int             SITE_W    = site_width(N_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [N_IN-1:0]   seed,
    input  logic [1:0]        fault_mode,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SITE_W-1:0] res_site,
    output logic [CNT_W-1:0]  res_count,
    output logic              done
);

    localparam int               PAT_W   = $clog2(N_PAT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e            state_reg, state_next;
    logic [N_IN-1:0]   seed_reg;
    fault_mode_e       mode_reg;
    logic [SITE_W-1:0] site_reg;
    logic [N_IN-1:0]   lfsr_reg;
    logic [PAT_W-1:0]  pat_idx_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              mismatch_reg;

    logic            golden_out;
    logic            faulty_out;
    logic            last_pat;
    logic            last_site;
    logic [N_IN-1:0] lfsr_step;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic b);
        return (c == CNT_MAX) ? c : c + CNT_W'(b);
    endfunction

    see_cone #(.N_IN(N_IN), .SITE_W(SITE_W)) u_golden (
        .in         (lfsr_reg),
        .fault_en   (1'b0),
        .fault_site ('0),
        .fault_mode (FM_NONE),
        .out        (golden_out)
    );

    see_cone #(.N_IN(N_IN), .SITE_W(SITE_W)) u_faulty (
        .in         (lfsr_reg),
        .fault_en   (1'b1),
        .fault_site (site_reg),
        .fault_mode (mode_reg),
        .out        (faulty_out)
    );

    assign lfsr_step = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? LFSR_TAPS : '0);
    assign last_pat  = (pat_idx_reg == PAT_W'(N_PAT - 1));
    assign last_site = (site_reg >= SITE_W'(N_IN - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:   if (start) state_next = ST_SEED;
                ST_SEED:   state_next = ST_RUN;
                ST_RUN:    if (last_pat) state_next = ST_FLUSH;
                ST_FLUSH:  state_next = ST_REPORT;
                ST_REPORT: if (res_ready) state_next = last_site ? ST_DONE : ST_SEED;
                ST_DONE:   state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // The mismatch of pattern i is accumulated one cycle later; FLUSH absorbs the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_reg     <= '0;
            mode_reg     <= FM_SA0;
            site_reg     <= '0;
            lfsr_reg     <= N_IN'(1);
            pat_idx_reg  <= '0;
            count_reg    <= '0;
            mismatch_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        seed_reg <= seed;
                        mode_reg <= fault_mode_e'(fault_mode);
                        site_reg <= '0;
                    end
                end
                ST_SEED: begin
                    lfsr_reg     <= (seed_reg == '0) ? N_IN'(1) : seed_reg;
                    pat_idx_reg  <= '0;
                    count_reg    <= '0;
                    mismatch_reg <= 1'b0;
                end
                ST_RUN: begin
                    lfsr_reg     <= lfsr_step;
                    pat_idx_reg  <= pat_idx_reg + PAT_W'(1);
                    mismatch_reg <= golden_out ^ faulty_out;
                    count_reg    <= sat_add(count_reg, mismatch_reg);
                end
                ST_FLUSH: begin
                    count_reg    <= sat_add(count_reg, mismatch_reg);
                    mismatch_reg <= 1'b0;
                end
                ST_REPORT: begin
                    if (res_ready && !abort && !last_site) begin
                        site_reg <= site_reg + SITE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg != ST_IDLE);
    assign res_valid = (state_reg == ST_REPORT);
    assign done      = (state_reg == ST_DONE);
    assign res_site  = site_reg;
    assign res_count = count_reg;

endmodule
